key_step_controller: RTL and testbench
======================================

Name: key_step_controller

Overview:
- Consumes the hold-mode w/a/s/q key levels from the PS/2 keyboard tracker and turns them into discrete cursor/player movement steps with typematic auto-repeat.
- Maintains a saturating (x, y) position and a pause flag toggled by q.
- Sits directly downstream of the keyboard tracker and feeds the game/draw logic with one-cycle step strobes plus the current position.

Parameters:
X_WIDTH, 8, width of x position
Y_WIDTH, 7, width of y position
X_MAX, 159, largest legal x (inclusive)
Y_MAX, 119, largest legal y (inclusive)
X_START, 80, x after reset
Y_START, 60, y after reset
CNT_WIDTH, 25, width of repeat timer
REPEAT_DELAY, 25000000, cycles from first step to first auto-repeat step (>=2)
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps (>=1)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
w  input  1  up key held (level, synchronous to clock)
a  input  1  left key held
s  input  1  down key held
q  input  1  pause key held
x  output  X_WIDTH  current x position
y  output  Y_WIDTH  current y position
step  output  1  one-cycle strobe: a step was taken this cycle
dir  output  2  direction of the last step: 0 up, 1 left, 2 down; holds between steps
bump  output  1  one-cycle strobe coincident with step when the position saturated (no change)
paused  output  1  pause state

Behaviour:
- Reset (reset low, async): x=X_START, y=Y_START, step=0, dir=0, bump=0, paused=0, FSM=IDLE, timer=0, q_prev=0. Reset asserted mid-hold aborts all activity; after release, a key still held counts as a new press only once it is seen low and then high again (edge detectors are reset to "held" = current key state sampled on the first cycle out of reset).
- All outputs registered. step and bump are high for exactly one cycle.
- Active key: highest-priority held key, W > A > S. If no key is held, the active key is none.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on a clock edge where the active key is not none and not paused, take a step in that direction and go to DELAY with timer=0.
  - DELAY: timer increments every cycle. When the timer reaches REPEAT_DELAY-1 with the same active key, take a step, go to REPEAT, and set timer=0.
  - REPEAT: when the timer reaches REPEAT_RATE-1, take a step and set timer=0.
  - DELAY/REPEAT: if the active key becomes none, go to IDLE with no step. If the active key changes to a different key, immediately step in the new direction, go to DELAY, and set timer=0.
- Latency: a key sampled high at edge k (low at k-1) gives step=1 and an updated x/y after edge k, visible during cycle k+1. The first repeat is REPEAT_DELAY cycles later; each further repeat is REPEAT_RATE cycles after that.
- Step arithmetic:
  - up: y-1, saturating at 0.
  - down: y+1, saturating at Y_MAX.
  - left: x-1, saturating at 0.
  - x never increments (no right key).
  - At saturation, step=1, bump=1, and position is unchanged. dir is updated on every step, including bump steps.
- Pause:
  - A rising edge of q toggles paused.
  - Entering pause forces FSM=IDLE, clears the timer, and suppresses all steps.
  - While paused, w/a/s are ignored.
  - Leaving pause with a key held starts a step in IDLE on the next edge, exactly as for a fresh press.
  - If a q rising edge and a step condition occur in the same cycle, the pause toggle wins when entering pause (no step); when leaving pause, no step is taken that cycle.
- Holding q does not re-toggle.

Test Plan:
- REPEAT_DELAY=4, REPEAT_RATE=2; reset release, hold w 11 cycles from cycle 0 -> step at cycles 1,5,7,9,11; y goes 60,59,58,57,56,55; dir=0.
- x=1 via start param X_START=1, tap a twice (1 cycle high, 2 low, 1 high) -> x=0 after first step; second step has bump=1, x stays 0, dir=1.
- Hold s, then additionally press w while in REPEAT -> immediate step with dir=0 on the cycle after w rises, timer restarts (next step 4 cycles later). Release w while s still held -> immediate step with dir=2.
- Pulse q one cycle while holding a -> paused=1, no further steps for 20 cycles; pulse q again -> paused=0 and a step on the next edge with dir=1.
- Assert reset asynchronously (between edges) during REPEAT -> x=80, y=60, step=0, paused=0 immediately. Release with w still held -> no step until w is released and pressed again.
- Y_START=Y_MAX=119, hold s through 3 repeats -> 4 steps all with bump=1, y=119 throughout.

Source files
------------

// File: rtl/key_step_controller.sv
// Turns held w/a/s key levels into discrete movement steps with typematic auto-repeat.
// Tracks a saturating (x, y) position and a pause flag toggled by rising edges of q.
module key_step_controller #(
   parameter int X_WIDTH      = 8,
   parameter int Y_WIDTH      = 7,
   parameter int X_MAX        = 159,
   parameter int Y_MAX        = 119,
   parameter int X_START      = 80,
   parameter int Y_START      = 60,
   parameter int CNT_WIDTH    = 25,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               w,
   input  logic               a,
   input  logic               s,
   input  logic               q,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               step,
   output logic [1:0]         dir,
   output logic               bump,
   output logic               paused
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [1:0] DIR_UP   = 2'd0;
   localparam logic [1:0] DIR_LEFT = 2'd1;
   localparam logic [1:0] DIR_DOWN = 2'd2;

   localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);
   localparam logic [X_WIDTH-1:0]   X_RST      = X_WIDTH'((X_START > X_MAX) ? X_MAX : X_START);
   localparam logic [Y_WIDTH-1:0]   Y_RST      = Y_WIDTH'((Y_START > Y_MAX) ? Y_MAX : Y_START);
   localparam logic [Y_WIDTH-1:0]   Y_TOP      = Y_WIDTH'(Y_MAX);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] timer_q, timer_d;
   logic [X_WIDTH-1:0]   x_q;
   logic [Y_WIDTH-1:0]   y_q;
   logic [1:0]           dir_q;
   logic                 step_q;
   logic                 bump_q;
   logic                 paused_q;
   logic                 q_prev_q;
   logic                 first_q;
   logic [2:0]           block_q;

   logic [2:0]           keys_raw_s;
   logic [2:0]           keys_eff_s;
   logic                 key_vld_s;
   logic [1:0]           key_dir_s;
   logic                 q_rise_s;
   logic                 take_step_s;
   logic [CNT_WIDTH-1:0] timer_last_s;
   logic [X_WIDTH-1:0]   nx_s;
   logic [Y_WIDTH-1:0]   ny_s;
   logic                 sat_s;

   assign keys_raw_s = {s, a, w};
   assign q_rise_s   = q & ~q_prev_q;

   // Keys still held across reset stay masked until they are seen released.
   always_comb begin
      keys_eff_s = 3'b000;
      if (first_q) begin
         keys_eff_s = 3'b000;
      end else begin
         keys_eff_s = keys_raw_s & ~block_q;
      end
      key_vld_s = |keys_eff_s;
      if (keys_eff_s[0]) begin
         key_dir_s = DIR_UP;
      end else if (keys_eff_s[1]) begin
         key_dir_s = DIR_LEFT;
      end else begin
         key_dir_s = DIR_DOWN;
      end
   end

   // Saturating position update for the active direction.
   always_comb begin
      nx_s  = x_q;
      ny_s  = y_q;
      sat_s = 1'b0;
      case (key_dir_s)
         DIR_UP: begin
            if (y_q == {Y_WIDTH{1'b0}}) sat_s = 1'b1;
            else                        ny_s  = y_q - Y_WIDTH'(1);
         end
         DIR_LEFT: begin
            if (x_q == {X_WIDTH{1'b0}}) sat_s = 1'b1;
            else                        nx_s  = x_q - X_WIDTH'(1);
         end
         DIR_DOWN: begin
            if (y_q >= Y_TOP) sat_s = 1'b1;
            else              ny_s  = y_q + Y_WIDTH'(1);
         end
         default: sat_s = 1'b0;
      endcase
   end

   // Step/repeat sequencing; a q edge or pause always parks the FSM in IDLE.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      take_step_s = 1'b0;
      if (state_q == ST_DELAY) timer_last_s = DELAY_LAST;
      else                     timer_last_s = RATE_LAST;
      if (q_rise_s || paused_q) begin
         state_d = ST_IDLE;
         timer_d = {CNT_WIDTH{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               timer_d = {CNT_WIDTH{1'b0}};
               if (key_vld_s) begin
                  take_step_s = 1'b1;
                  state_d     = ST_DELAY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_DELAY, ST_REPEAT: begin
               if (!key_vld_s) begin
                  state_d = ST_IDLE;
                  timer_d = {CNT_WIDTH{1'b0}};
               end else if (key_dir_s != dir_q) begin
                  take_step_s = 1'b1;
                  state_d     = ST_DELAY;
                  timer_d     = {CNT_WIDTH{1'b0}};
               end else if (timer_q == timer_last_s) begin
                  take_step_s = 1'b1;
                  state_d     = ST_REPEAT;
                  timer_d     = {CNT_WIDTH{1'b0}};
               end else begin
                  timer_d = timer_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = {CNT_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // State, position and strobe registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= {CNT_WIDTH{1'b0}};
         x_q      <= X_RST;
         y_q      <= Y_RST;
         dir_q    <= DIR_UP;
         step_q   <= 1'b0;
         bump_q   <= 1'b0;
         paused_q <= 1'b0;
         q_prev_q <= 1'b0;
         first_q  <= 1'b1;
         block_q  <= 3'b111;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         q_prev_q <= q;
         first_q  <= 1'b0;
         step_q   <= take_step_s;
         bump_q   <= take_step_s & sat_s;
         if (first_q) block_q <= keys_raw_s;
         else         block_q <= block_q & keys_raw_s;
         if (q_rise_s) paused_q <= ~paused_q;
         else          paused_q <= paused_q;
         if (take_step_s) begin
            dir_q <= key_dir_s;
            x_q   <= nx_s;
            y_q   <= ny_s;
         end else begin
            dir_q <= dir_q;
            x_q   <= x_q;
            y_q   <= y_q;
         end
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign step   = step_q;
   assign dir    = dir_q;
   assign bump   = bump_q;
   assign paused = paused_q;

endmodule

// File: tb/tb_key_step_controller.sv
// Scoreboard bench for key_step_controller: three instances with different start positions,
// expected step events queued as keys are driven and matched against every observed step strobe.
module tb_key_step_controller;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       w_v [3];
   logic       a_v [3];
   logic       s_v [3];
   logic       q_v [3];
   logic [7:0] x_o [3];
   logic [6:0] y_o [3];
   logic       step_o [3];
   logic [1:0] dir_o [3];
   logic       bump_o [3];
   logic       paused_o [3];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t0;
   int c1;

   typedef struct {
      int id;
      int cyc;
      int x;
      int y;
      int dir;
      int bump;
   } exp_t;
   exp_t sb_q[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   key_step_controller #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_a (
      .clock(clock), .reset(rst_n), .w(w_v[0]), .a(a_v[0]), .s(s_v[0]), .q(q_v[0]),
      .x(x_o[0]), .y(y_o[0]), .step(step_o[0]), .dir(dir_o[0]), .bump(bump_o[0]), .paused(paused_o[0]));

   key_step_controller #(.X_START(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_b (
      .clock(clock), .reset(rst_n), .w(w_v[1]), .a(a_v[1]), .s(s_v[1]), .q(q_v[1]),
      .x(x_o[1]), .y(y_o[1]), .step(step_o[1]), .dir(dir_o[1]), .bump(bump_o[1]), .paused(paused_o[1]));

   key_step_controller #(.Y_START(119), .Y_MAX(119), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_c (
      .clock(clock), .reset(rst_n), .w(w_v[2]), .a(a_v[2]), .s(s_v[2]), .q(q_v[2]),
      .x(x_o[2]), .y(y_o[2]), .step(step_o[2]), .dir(dir_o[2]), .bump(bump_o[2]), .paused(paused_o[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sb_push(input int id, input int c, input int xe, input int ye, input int de, input int be);
      exp_t e;
      e.id = id; e.cyc = c; e.x = xe; e.y = ye; e.dir = de; e.bump = be;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int id);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("unexpected_step_queue_size", sb_q.size(), 1);
      end else begin
         e = sb_q.pop_front();
         check_val("step_dut", id, e.id);
         check_val("step_cycle", cyc, e.cyc);
         check_val("step_x", x_o[id], e.x);
         check_val("step_y", y_o[id], e.y);
         check_val("step_dir", dir_o[id], e.dir);
         check_val("step_bump", bump_o[id], e.bump);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   // Scoreboard monitor on the falling edge.
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (step_o[i] === 1'b1) sb_pop(i);
         if (bump_o[i] === 1'b1 && step_o[i] !== 1'b1) check_val("bump_without_step", step_o[i], 1);
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w_v[i] = 1'b0; a_v[i] = 1'b0; s_v[i] = 1'b0; q_v[i] = 1'b0;
      end
      tick(3);
      check_val("rst_x_a", x_o[0], 80);
      check_val("rst_y_a", y_o[0], 60);
      check_val("rst_step_a", step_o[0], 0);
      check_val("rst_dir_a", dir_o[0], 0);
      check_val("rst_bump_a", bump_o[0], 0);
      check_val("rst_paused_a", paused_o[0], 0);
      check_val("rst_x_b", x_o[1], 1);
      check_val("rst_y_c", y_o[2], 119);
      rst_n = 1'b1;
      tick(3);

      // Hold w for 11 edges: steps at +1, +5, +7, +9, +11.
      t0 = cyc;
      sb_push(0, t0 + 1, 80, 59, 0, 0);
      sb_push(0, t0 + 5, 80, 58, 0, 0);
      sb_push(0, t0 + 7, 80, 57, 0, 0);
      sb_push(0, t0 + 9, 80, 56, 0, 0);
      sb_push(0, t0 + 11, 80, 55, 0, 0);
      w_v[0] = 1'b1;
      tick(11);
      w_v[0] = 1'b0;
      tick(3);
      check_val("hold_w_final_y", y_o[0], 55);
      check_val("hold_w_final_dir", dir_o[0], 0);

      // Two taps of a starting from x=1: second step saturates.
      t0 = cyc;
      sb_push(1, t0 + 1, 0, 60, 1, 0);
      sb_push(1, t0 + 4, 0, 60, 1, 1);
      a_v[1] = 1'b1; tick(1);
      a_v[1] = 1'b0; tick(2);
      a_v[1] = 1'b1; tick(1);
      a_v[1] = 1'b0; tick(3);
      check_val("left_sat_x", x_o[1], 0);

      // Hold s, add w during repeat, then release w.
      t0 = cyc;
      sb_push(0, t0 + 1, 80, 56, 2, 0);
      sb_push(0, t0 + 5, 80, 57, 2, 0);
      sb_push(0, t0 + 7, 80, 58, 2, 0);
      sb_push(0, t0 + 8, 80, 57, 0, 0);
      sb_push(0, t0 + 12, 80, 56, 0, 0);
      sb_push(0, t0 + 13, 80, 57, 2, 0);
      s_v[0] = 1'b1; tick(7);
      w_v[0] = 1'b1; tick(5);
      w_v[0] = 1'b0; tick(1);
      s_v[0] = 1'b0; tick(3);
      check_val("switch_final_y", y_o[0], 57);
      check_val("switch_final_dir", dir_o[0], 2);

      // Pause while holding a, then resume.
      t0 = cyc;
      sb_push(0, t0 + 1, 79, 57, 1, 0);
      a_v[0] = 1'b1; tick(2);
      q_v[0] = 1'b1; tick(1);
      q_v[0] = 1'b0;
      check_val("pause_enter", paused_o[0], 1);
      tick(20);
      check_val("pause_hold", paused_o[0], 1);
      check_val("pause_x_frozen", x_o[0], 79);
      c1 = cyc;
      sb_push(0, c1 + 2, 78, 57, 1, 0);
      q_v[0] = 1'b1; tick(1);
      q_v[0] = 1'b0;
      check_val("pause_leave", paused_o[0], 0);
      check_val("pause_leave_no_step", step_o[0], 0);
      tick(1);
      a_v[0] = 1'b0; tick(3);
      check_val("resume_x", x_o[0], 78);

      // Asynchronous reset in REPEAT, release with w still held.
      t0 = cyc;
      sb_push(0, t0 + 1, 78, 56, 0, 0);
      sb_push(0, t0 + 5, 78, 55, 0, 0);
      sb_push(0, t0 + 7, 78, 54, 0, 0);
      w_v[0] = 1'b1; tick(8);
      #1 rst_n = 1'b0;
      #1;
      check_val("async_rst_x", x_o[0], 80);
      check_val("async_rst_y", y_o[0], 60);
      check_val("async_rst_step", step_o[0], 0);
      check_val("async_rst_paused", paused_o[0], 0);
      tick(2);
      #1 rst_n = 1'b1;
      tick(6);
      check_val("held_after_rst_y", y_o[0], 60);
      w_v[0] = 1'b0; tick(2);
      t0 = cyc;
      sb_push(0, t0 + 1, 80, 59, 0, 0);
      w_v[0] = 1'b1; tick(1);
      w_v[0] = 1'b0; tick(3);
      check_val("repress_y", y_o[0], 59);

      // Hold s at the bottom edge through three repeats.
      t0 = cyc;
      sb_push(2, t0 + 1, 80, 119, 2, 1);
      sb_push(2, t0 + 5, 80, 119, 2, 1);
      sb_push(2, t0 + 7, 80, 119, 2, 1);
      sb_push(2, t0 + 9, 80, 119, 2, 1);
      s_v[2] = 1'b1; tick(9);
      s_v[2] = 1'b0; tick(3);
      check_val("bottom_sat_y", y_o[2], 119);
      check_val("bottom_sat_dir", dir_o[2], 2);

      tick(2);
      check_val("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
